// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin arbiter sharing one UART TX FIFO write port
// between NREQ byte-stream requesters. A grant is held for a whole packet
// (or MAX_BURST bytes, whichever comes first) and then rotates fairly.
module uart_tx_sched #(
  parameter int NREQ      = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 16,
  localparam int ID_W     = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int CNT_W    = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*DATA_W-1:0] req_data,
  input  logic [NREQ-1:0]        req_last,
  output logic [NREQ-1:0]        req_ready,
  input  logic                   fifo_full,
  output logic                   fifo_wr_en,
  output logic [DATA_W-1:0]      fifo_wr_data,
  output logic                   grant_valid,
  output logic [ID_W-1:0]        grant_id,
  output logic                   pkt_done
);

  typedef enum logic {IDLE, XFER} state_t;

  state_t           state;
  logic [ID_W-1:0]  last_id;
  logic [CNT_W-1:0] beat_cnt;

  logic [ID_W-1:0]  pick;
  logic             found;
  int               scan_idx;

  logic             own_valid;
  logic             own_last;
  logic             release_now;

  // Rotating priority pick: first valid requester after the previous owner.
  always_comb begin
    pick     = '0;
    found    = 1'b0;
    scan_idx = 0;
    for (int k = 1; k <= NREQ; k++) begin
      scan_idx = (int'(last_id) + k) % NREQ;
      if (!found && req_valid[ID_W'(scan_idx)]) begin
        pick  = ID_W'(scan_idx);
        found = 1'b1;
      end
    end
  end

  // Owner-side muxing of valid/last/data and the ready/write strobes.
  // Reset gates the strobes so a mid-packet reset can never write the FIFO.
  always_comb begin
    own_valid    = 1'b0;
    own_last     = 1'b0;
    fifo_wr_data = '0;
    req_ready    = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_id == ID_W'(i)) begin
        own_valid    = req_valid[i];
        own_last     = req_last[i];
        fifo_wr_data = req_data[i*DATA_W +: DATA_W];
        req_ready[i] = rst_n && (state == XFER) && !fifo_full;
      end
    end
    fifo_wr_en  = rst_n && (state == XFER) && own_valid && !fifo_full;
    release_now = fifo_wr_en && (own_last || (beat_cnt == CNT_W'(MAX_BURST - 1)));
  end

  // Arbitration / transfer state machine with registered grant outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      pkt_done    <= 1'b0;
      beat_cnt    <= '0;
      last_id     <= ID_W'(NREQ - 1);
    end else begin
      pkt_done <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            grant_id    <= pick;
            grant_valid <= 1'b1;
            beat_cnt    <= '0;
            state       <= XFER;
          end
        end
        XFER: begin
          if (fifo_wr_en) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (release_now) begin
              state       <= IDLE;
              last_id     <= grant_id;
              grant_valid <= 1'b0;
              grant_id    <= '0;
              pkt_done    <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Round-robin scheduler that shares the single UART transmit path (TX FIFO and serializer) between `NREQ` byte-stream requesters. It sits directly upstream of the TX FIFO write port. It grants one requester at a time and forwards its bytes into the FIFO under FIFO backpressure. A grant is held for a whole packet, up to `MAX_BURST` bytes, before rotating fairly to the next requester.

## Interface
- `NREQ`, 4, number of requesters (2..8)
- `DATA_W`, 8, byte width
- `MAX_BURST`, 16, max bytes forwarded per grant before forced rotation (>=1)
- `clk`  in  1  clock; all logic on rising edge
- `rst_n`  in  1  reset, synchronous, active-low; clock clk
- `req_valid`  in  NREQ  per-requester byte valid
- `req_data`  in  NREQ*DATA_W  per-requester byte; requester i at bits [i*DATA_W +: DATA_W]
- `req_last`  in  NREQ  marks the final byte of a packet; qualified by valid
- `req_ready`  out  NREQ  one-hot or zero; byte accepted when valid&&ready
- `fifo_full`  in  1  TX FIFO full
- `fifo_wr_en`  out  1  TX FIFO write strobe
- `fifo_wr_data`  out  DATA_W  byte to the FIFO
- `grant_valid`  out  1  a requester currently owns the path
- `grant_id`  out  clog2(NREQ)  index of the owner; 0 when `grant_valid`=0
- `pkt_done`  out  1  one-cycle pulse, registered, on each grant release

## Operation
- State machine with two states, IDLE and XFER. Internal regs: `grant_id`, `last_id`, and `beat_cnt` (width clog2(MAX_BURST), minimum 1).
- IDLE
  - `req_ready`=0 and `fifo_wr_en`=0.
  - If any `req_valid` is high: pick the first asserted index scanning `last_id+1`, `last_id+2`, ... modulo NREQ.
  - Register the pick into `grant_id`, set `grant_valid`=1, clear `beat_cnt`, and go to XFER.
  - Otherwise stay in IDLE.
- XFER, owner g
  - `req_ready[g]` = !`fifo_full`; all other `req_ready` bits are 0.
  - `fifo_wr_en` = `req_valid[g]` && !`fifo_full`, combinational.
  - `fifo_wr_data` = `req_data[g]`, combinational mux.
- Transfer in XFER (wr_en=1): `beat_cnt` increments.
- Release occurs on a transfer where `req_last[g]`=1 or `beat_cnt`==MAX_BURST-1. On release:
  - next state is IDLE;
  - `last_id`<=g;
  - `grant_valid`<=0 and `grant_id`<=0;
  - `pkt_done`<=1 for the next cycle only.
- Packet lock: if `req_valid[g]` drops mid-packet, the grant is held indefinitely and no other requester is served.
- `fifo_full` stalls the transfer (no write, no count) but does not release the grant.
- Requests from non-owners are ignored until the next IDLE arbitration; they must hold valid.
- MAX_BURST=1: every transfer releases.

## Timing
- Reset values: state IDLE, `grant_valid`=0, `grant_id`=0, `pkt_done`=0, `beat_cnt`=0, `last_id`=NREQ-1 (so requester 0 wins first).
- While `rst_n`=0, `req_ready` and `fifo_wr_en` are forced to 0, even if state was XFER. Reset mid-packet drops the grant; the partially sent packet is not resumed.
- Request to first acceptance: valid seen in IDLE at cycle N, grant at N+1, first byte accepted at N+1 if FIFO not full.
- Throughput: one byte per clock while owner valid and FIFO not full.
- Each release costs exactly one IDLE arbitration cycle before the next grant.
- `fifo_full` is sampled combinationally in the same cycle; the FIFO must never see `fifo_wr_en` while `fifo_full`=1.
- `pkt_done` rises the cycle after the releasing transfer, coincident with `grant_valid` falling.

## Test plan
- Reset then a 3-byte packet 0xA1,0xA2,0xA3(last) on req 2 only:
  - grant_id=2 one cycle after valid;
  - three consecutive fifo_wr_en with those bytes;
  - pkt_done one pulse; back to IDLE.
- All 4 requesters continuously valid with 1-byte packets:
  - grant order 0,1,2,3,0,...;
  - one write every 2 cycles.
- Req 1 sends 20 bytes with no last, MAX_BURST=16, req 3 also valid:
  - forced release after 16 bytes;
  - req 3 granted next;
  - req 1 resumes its remaining 4 bytes afterwards.
- fifo_full held high 5 cycles mid-packet:
  - no fifo_wr_en and req_ready=0 during those cycles;
  - grant retained;
  - no byte lost or duplicated; count resumes.
- Owner drops valid for 3 cycles mid-packet while req 0 valid:
  - req 0 never readied;
  - packet completes after owner resumes.
- rst_n low for one cycle during XFER:
  - fifo_wr_en=0 that cycle;
  - next cycle all outputs at reset values;
  - next arbitration starts scanning at requester 0.
